vga_display_reader: RTL
=======================

# vga_display_reader

Read-side VGA controller for the edge-detection display path. Generates 640x480@60 VGA timing, issues reads into the ping-pong binary-image buffer, and maps each 1-bit pixel to RGB565 inside a centred 320x200 window (x 160..479, y 140..339). Sits between the frame-buffer writer, which supplies `dout`/`wr_end` and consumes `rd_addr`/`rd_en`/`rd_end`/`rd_addr_sel`, and the VGA pins. Owns the bank-swap half of the ping-pong handshake.

## Interface
- `FG_COLOR`, 16'hFFFF, RGB565 for window pixel = 1
- `BK_COLOR`, 16'h0000, RGB565 for window pixel = 0
- `BG_COLOR`, 16'h001F, RGB565 for active area outside window, and for the window before the first swap
- `clk`  in  1  pixel clock (25 MHz nominal)
- `rst`  in  1  reset; one clock; synchronous, active-high
- `wr_end`  in  1  writer has a complete frame in its bank; held until `rd_end` is seen
- `dout`  in  1  buffer read data; valid one cycle after `rd_en`/`rd_addr` are sampled by the RAM
- `rd_addr`  out  16  buffer read address, 0..63999
- `rd_en`  out  1  buffer read enable
- `rd_end`  out  1  one-cycle pulse acknowledging `wr_end`; marks bank swap
- `rd_addr_sel`  out  1  bank select; 0 = read bank 1 / write bank 0, 1 = read bank 0 / write bank 1
- `vga_hs`  out  1  horizontal sync, active low
- `vga_vs`  out  1  vertical sync, active low
- `vga_de`  out  1  active video
- `vga_rgb`  out  16  RGB565 pixel

## Operation
- `hcnt` 0..799, wraps; `vcnt` 0..524, increments when `hcnt`==799, wraps at 524.
- H regions: sync 0..95, back porch 96..143, active 144..783, front porch 784..799. V regions: sync 0..1, back porch 2..34, active 35..514, front porch 515..524.
- Pixel coords: x = `hcnt`-144, y = `vcnt`-35. Window: `hcnt` 304..623 and `vcnt` 175..374.
- In window: `rd_en`=1, `rd_addr` = (y-140)*320 + (x-160). 16-bit unsigned arithmetic, no overflow in range. Outside window: `rd_en`=0, `rd_addr`=0.
- Swap FSM, states IDLE/SWAP:
  - IDLE -> SWAP when `hcnt`==799, `vcnt`==524 and `wr_end`==1.
  - SWAP lasts one cycle: `rd_end`=1, `rd_addr_sel` toggled on entry, `buf_valid` set. Then back to IDLE.
  - With `wr_end`==0 at frame end: no swap; the same bank is redisplayed.
- Exactly one swap per frame at most. `wr_end` still high in the cycle after `rd_end` causes no second swap, because the check happens only at frame end.
- Colour mux at output stage:
  - not active: 0
  - active, outside window: `BG_COLOR`
  - window with `buf_valid`==0: `BG_COLOR`
  - window with `buf_valid`==1: `dout` ? `FG_COLOR` : `BK_COLOR`

## Timing
- Stage 0: counters.
- Stage 1: `rd_en`/`rd_addr` registered.
- Stage 2: `dout` valid.
- Stage 3: `vga_rgb`/`vga_de`/`vga_hs`/`vga_vs` registered.
- Sync, de and window flags are delayed through a 3-stage shift so all pins align. Pin latency is 3 cycles from counter value.
- `rd_end` and the `rd_addr_sel` toggle appear on the same edge: the one where counters wrap to (0,0). The window is not being read at that point.
- Reset values: `hcnt`=`vcnt`=0, `rd_addr`=0, `rd_en`=0, `rd_end`=0, `rd_addr_sel`=0, `buf_valid`=0, `vga_hs`=1, `vga_vs`=1, `vga_de`=0, `vga_rgb`=0, pipeline cleared.
- Reset mid-frame: all of the above restored next edge, timing restarts at (0,0), `buf_valid` cleared. The writer's pending `wr_end` is honoured at the next frame end.
- Frame period: 420000 clocks.

## Test plan
- Reset, then run 2 frames with `wr_end`=0: `vga_hs` low 96 of every 800 clocks; `vga_vs` low for 1600 clocks every 420000; `vga_de` high 640x480 per frame; window pixels = 16'h001F; `rd_end` never pulses; `rd_addr_sel` stays 0.
- Hold `wr_end`=1 across a frame end: exactly one `rd_end` pulse, at the cycle counters read (0,0). `rd_addr_sel` becomes 1. A model writer dropping `wr_end` on `rd_end` produces no second pulse.
- Addressing: `rd_en` high 64000 cycles per frame. The first `rd_addr`=0 appears one cycle after `hcnt`=304, `vcnt`=175. The last is 63999. The first address of row y=141 is 320.
- Data path, after one swap, `dout`=1 only for `rd_addr`=5: `vga_rgb`=16'hFFFF 3 cycles after the counter at x=165, y=140; all other window pixels 16'h0000.
- Assert `rst` for 1 cycle mid-line of a displayed frame: all outputs reach reset values next edge, `rd_addr_sel` returns to 0, and window pixels show `BG_COLOR` until the next swap.

Source files
------------

// File: rtl/vga_display_reader_if.sv
// ---------------------------------------------------------------------------
// vga_display_reader_if
// Bundles the frame-buffer read/handshake signals and the VGA pin group of
// the edge-detection display path.
//   master : the display reader (drives buffer reads, swap ack, VGA pins)
//   slave  : the frame-buffer side / pins consumer (drives wr_end, dout)
// Signals:
//   wr_end      writer has a complete frame in its bank
//   dout        1-bit buffer read data (one cycle after rd_en/rd_addr)
//   rd_addr     buffer read address
//   rd_en       buffer read enable
//   rd_end      one-cycle bank-swap acknowledge
//   rd_addr_sel bank select (0: read bank 1, 1: read bank 0)
//   vga_hs/vs   syncs, active low
//   vga_de      active video
//   vga_rgb     RGB565 pixel
// ---------------------------------------------------------------------------
interface vga_display_reader_if;
  logic        wr_end;
  logic        dout;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic        rd_end;
  logic        rd_addr_sel;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [15:0] vga_rgb;

  modport master (
    input  wr_end, dout,
    output rd_addr, rd_en, rd_end, rd_addr_sel,
    output vga_hs, vga_vs, vga_de, vga_rgb
  );

  modport slave (
    output wr_end, dout,
    input  rd_addr, rd_en, rd_end, rd_addr_sel,
    input  vga_hs, vga_vs, vga_de, vga_rgb
  );
endinterface

// File: rtl/vga_display_reader.sv
// ---------------------------------------------------------------------------
// vga_display_reader
// Read side of the ping-pong binary-image buffer. Generates VGA timing
// (640x480@60 by default), reads a 1-bit image inside a centred window and
// maps it to RGB565. Owns the bank swap: at frame end, if the writer reports
// a complete frame (wr_end), the read bank toggles and rd_end pulses once.
// Ports:
//   clk  pixel clock
//   rst  synchronous, active-high reset
//   bus  vga_display_reader_if.master (buffer handshake + VGA pins)
// Pipeline: counters -> rd_en/rd_addr reg -> dout (RAM) -> pin regs.
// All pins are 3 cycles behind the counter value that produced them.
// Geometry parameters default to 640x480@60 with a 320x200 window at
// pixel (160,140); they exist so the timing can be scaled down.
// ---------------------------------------------------------------------------
module vga_display_reader #(
  parameter logic [15:0] FG_COLOR = 16'hFFFF,
  parameter logic [15:0] BK_COLOR = 16'h0000,
  parameter logic [15:0] BG_COLOR = 16'h001F,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int WIN_X  = 160,
  parameter int WIN_Y  = 140,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_display_reader_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Region bounds in counter space; upper bounds are exclusive.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT0     = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT1     = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [HW-1:0] H_WIN0     = HW'(H_SYNC + H_BP + WIN_X);
  localparam logic [HW-1:0] H_WIN1     = HW'(H_SYNC + H_BP + WIN_X + WIN_W);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT0     = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT1     = VW'(V_SYNC + V_BP + V_ACT);
  localparam logic [VW-1:0] V_WIN0     = VW'(V_SYNC + V_BP + WIN_Y);
  localparam logic [VW-1:0] V_WIN1     = VW'(V_SYNC + V_BP + WIN_Y + WIN_H);

  localparam logic [15:0] H_WIN0_16 = 16'(H_SYNC + H_BP + WIN_X);
  localparam logic [15:0] V_WIN0_16 = 16'(V_SYNC + V_BP + WIN_Y);
  localparam logic [15:0] WIN_W_16  = 16'(WIN_W);

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic win;
  } flags_t;

  // Syncs idle high so the pins stay deasserted while the pipe refills.
  localparam flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0};

  typedef enum logic {IDLE, SWAP} state_t;

  logic [HW-1:0] hcnt_reg;
  logic [VW-1:0] vcnt_reg;
  logic          frame_end;

  flags_t        flags_now;
  flags_t        pipe_reg [0:1];
  logic [15:0]   col_off;
  logic [15:0]   row_off;
  logic [15:0]   addr_now;

  logic          rd_en_reg;
  logic [15:0]   rd_addr_reg;

  state_t        state_reg;
  state_t        state_next;
  logic          swap_start;
  logic          rd_addr_sel_reg;
  logic          buf_valid_reg;

  logic [15:0]   rgb_next;
  logic          vga_hs_reg;
  logic          vga_vs_reg;
  logic          vga_de_reg;
  logic [15:0]   vga_rgb_reg;

  // Stage 0: raster counters
  assign frame_end = (hcnt_reg == H_LAST) && (vcnt_reg == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (hcnt_reg == H_LAST) begin
      hcnt_reg <= '0;
      vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
    end else begin
      hcnt_reg <= hcnt_reg + 1'b1;
    end
  end

  // Region decode and window address for the current counter value
  always_comb begin
    flags_now.hs  = (hcnt_reg >= H_SYNC_END);
    flags_now.vs  = (vcnt_reg >= V_SYNC_END);
    flags_now.de  = (hcnt_reg >= H_ACT0) && (hcnt_reg < H_ACT1) &&
                    (vcnt_reg >= V_ACT0) && (vcnt_reg < V_ACT1);
    flags_now.win = (hcnt_reg >= H_WIN0) && (hcnt_reg < H_WIN1) &&
                    (vcnt_reg >= V_WIN0) && (vcnt_reg < V_WIN1);
    col_off  = 16'(hcnt_reg) - H_WIN0_16;
    row_off  = 16'(vcnt_reg) - V_WIN0_16;
    addr_now = row_off * WIN_W_16 + col_off;
  end

  // Stage 1: buffer read request
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      rd_en_reg   <= flags_now.win;
      rd_addr_reg <= flags_now.win ? addr_now : 16'd0;
    end
  end

  // Flags ride two registers so that, with the pin register, they land
  // alongside the pixel whose dout arrives from the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        pipe_reg[i] <= FLAGS_IDLE;
      end
    end else begin
      pipe_reg[0] <= flags_now;
      pipe_reg[1] <= pipe_reg[0];
    end
  end

  // Swap FSM: the check is made only at frame end, so a wr_end that lingers
  // after rd_end cannot cause a second swap in the same frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    swap_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_end && bus.wr_end) begin
          state_next = SWAP;
          swap_start = 1'b1;
        end
      end
      SWAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bank select toggles on the same edge that enters SWAP, i.e. the edge
  // where the counters wrap to (0,0), well away from the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_sel_reg <= 1'b0;
      buf_valid_reg   <= 1'b0;
    end else if (swap_start) begin
      rd_addr_sel_reg <= ~rd_addr_sel_reg;
      buf_valid_reg   <= 1'b1;
    end
  end

  // Stage 3: colour mux and pin registers
  always_comb begin
    rgb_next = 16'h0000;
    if (pipe_reg[1].de) begin
      if (pipe_reg[1].win && buf_valid_reg) begin
        rgb_next = bus.dout ? FG_COLOR : BK_COLOR;
      end else begin
        rgb_next = BG_COLOR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs_reg  <= 1'b1;
      vga_vs_reg  <= 1'b1;
      vga_de_reg  <= 1'b0;
      vga_rgb_reg <= 16'h0000;
    end else begin
      vga_hs_reg  <= pipe_reg[1].hs;
      vga_vs_reg  <= pipe_reg[1].vs;
      vga_de_reg  <= pipe_reg[1].de;
      vga_rgb_reg <= rgb_next;
    end
  end

  assign bus.rd_en       = rd_en_reg;
  assign bus.rd_addr     = rd_addr_reg;
  assign bus.rd_end      = (state_reg == SWAP);
  assign bus.rd_addr_sel = rd_addr_sel_reg;
  assign bus.vga_hs      = vga_hs_reg;
  assign bus.vga_vs      = vga_vs_reg;
  assign bus.vga_de      = vga_de_reg;
  assign bus.vga_rgb     = vga_rgb_reg;

endmodule
